mem_stage: RTL

Memory-access stage of the RISC-V pipeline, between the EX/MEM latch and the MEM/WB latch that drives the register file write port (we/waddr/wdata). It passes ALU results through in one cycle and performs loads and stores over the 8-bit external memory bus one byte per cycle. While an access is in progress it stalls upstream. It delivers the assembled, sign/zero-extended load result as a registered write-back.

---
 rtl/mem_stage.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RISC-V memory stage: ALU pass-through and byte-serial load/store over an 8-bit bus
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy_in,
    input  logic        ex_valid,
    input  logic [3:0]  ex_memop,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_sdata,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic [31:0] ex_wdata,
    output logic        stall_req,
    output logic [31:0] mem_a,
    output logic [7:0]  mem_dout,
    output logic        mem_wr,
    input  logic [7:0]  mem_din,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_waddr,
    output logic [31:0] wb_wdata
);
    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_STORE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  op_q;
    logic [4:0]  wd_q;
    logic        wreg_q;
    logic [23:0] sdata_q;
    logic [31:0] ld_buf_q;
    logic [2:0]  cnt_q;

    logic        ex_is_load, ex_is_store;
    logic [2:0]  nbytes;
    logic        load_last, store_last;
    logic [31:0] ld_word, ld_ext;

    function automatic logic [2:0] op_bytes(input logic [3:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: op_bytes = 3'd1;
            OP_LH, OP_LHU, OP_SH: op_bytes = 3'd2;
            default:              op_bytes = 3'd4;
        endcase
    endfunction

    // In LOAD, cnt_q runs 0..N: the data for the byte addressed at count k arrives at count k+1.
    always_comb begin
        ex_is_load  = (ex_memop >= OP_LB) && (ex_memop <= OP_LHU);
        ex_is_store = (ex_memop >= OP_SB) && (ex_memop <= OP_SW);
        nbytes      = op_bytes(op_q);
        load_last   = (cnt_q == nbytes);
        store_last  = (cnt_q == nbytes - 3'd1);
    end

    always_comb begin
        ld_word = ld_buf_q;
        case (cnt_q)
            3'd1:    ld_word[7:0]   = mem_din;
            3'd2:    ld_word[15:8]  = mem_din;
            3'd3:    ld_word[23:16] = mem_din;
            3'd4:    ld_word[31:24] = mem_din;
            default: ;
        endcase
    end

    always_comb begin
        case (op_q)
            OP_LB:   ld_ext = {{24{ld_word[7]}}, ld_word[7:0]};
            OP_LH:   ld_ext = {{16{ld_word[15]}}, ld_word[15:0]};
            OP_LBU:  ld_ext = {24'h0, ld_word[7:0]};
            OP_LHU:  ld_ext = {16'h0, ld_word[15:0]};
            default: ld_ext = ld_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (rdy_in) begin
            case (state_q)
                S_IDLE: begin
                    if (ex_valid && ex_is_load) begin
                        state_d = S_LOAD;
                    end else if (ex_valid && ex_is_store) begin
                        state_d = S_STORE;
                    end
                end
                S_LOAD:  if (load_last)  state_d = S_IDLE;
                S_STORE: if (store_last) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        stall_req = (state_q != S_IDLE) || (ex_valid && (ex_is_load || ex_is_store));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= 4'd0;
            wd_q     <= 5'd0;
            wreg_q   <= 1'b0;
            sdata_q  <= 24'd0;
            ld_buf_q <= 32'd0;
            cnt_q    <= 3'd0;
            mem_a    <= 32'd0;
            mem_dout <= 8'd0;
            mem_wr   <= 1'b0;
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            wb_waddr <= 5'd0;
            wb_wdata <= 32'd0;
        end else if (rdy_in) begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (ex_valid) begin
                        op_q     <= ex_memop;
                        wd_q     <= ex_wd;
                        wreg_q   <= ex_wreg;
                        cnt_q    <= 3'd0;
                        ld_buf_q <= 32'd0;
                        if (ex_is_load) begin
                            mem_a  <= ex_addr;
                            mem_wr <= 1'b0;
                        end else if (ex_is_store) begin
                            mem_a    <= ex_addr;
                            mem_dout <= ex_sdata[7:0];
                            sdata_q  <= ex_sdata[31:8];
                            mem_wr   <= 1'b1;
                        end else begin
                            wb_valid <= 1'b1;
                            wb_we    <= ex_wreg && (ex_wd != 5'd0);
                            wb_waddr <= ex_wd;
                            wb_wdata <= ex_wdata;
                        end
                    end
                end
                S_LOAD: begin
                    ld_buf_q <= ld_word;
                    cnt_q    <= cnt_q + 3'd1;
                    if (cnt_q < nbytes - 3'd1) begin
                        mem_a <= mem_a + 32'd1;
                    end
                    if (load_last) begin
                        mem_a    <= 32'd0;
                        wb_valid <= 1'b1;
                        wb_we    <= wreg_q && (wd_q != 5'd0);
                        wb_waddr <= wd_q;
                        wb_wdata <= ld_ext;
                    end
                end
                S_STORE: begin
                    if (store_last) begin
                        mem_wr   <= 1'b0;
                        mem_a    <= 32'd0;
                        mem_dout <= 8'd0;
                        wb_valid <= 1'b1;
                        wb_waddr <= wd_q;
                    end else begin
                        mem_a    <= mem_a + 32'd1;
                        mem_dout <= sdata_q[7:0];
                        sdata_q  <= {8'h0, sdata_q[23:8]};
                        cnt_q    <= cnt_q + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
